led_frame_tx: RTL
=================

Name: led_frame_tx

Overview:
- Host-side serial transmitter for the LED display driver.
- Accepts 16-bit pixel words over a valid/ready handshake and shifts them LSB-first onto DAI, with DEN high for 16 DCK periods per pixel.
- After each pixel, inserts a DEN-low gap so the driver can commit the word to its frame SRAM.
- Raises Vsync once the first full frame has been delivered. Sits between the frame source and the LED driver's DCK/DAI/DEN/Vsync pins.

Parameters:
PIX_BITS, 16, bits per pixel word; shifted LSB first.
PIX_PER_FRAME, 512, pixel words per frame (32 scanlines x 16 channels).
GAP_DCK, 2, DEN-low DCK periods after each pixel; legal range 1..15.

Ports:
clk  input  1  system clock; DCK is derived at clk/2.
rst  input  1  synchronous, active-high reset.
frame_start  input  1  one-cycle pulse; begins a frame when idle.
pix_valid  input  1  pix_data holds a valid word.
pix_ready  output  1  block accepts a word this cycle.
pix_data  input  PIX_BITS  pixel word.
DCK  output  1  serial data clock to the driver.
DAI  output  1  serial data bit.
DEN  output  1  data enable; high while a word is shifting.
Vsync  output  1  frame-valid level to the driver.
busy  output  1  frame in progress.
frame_done  output  1  one-clk pulse when the last gap completes.

Behaviour:
- Reset (rst=1 at a clk edge) forces all of the following, regardless of state, including mid-frame:
  - DCK=0, DAI=0, DEN=0, Vsync=0, pix_ready=0, busy=0, frame_done=0.
  - State IDLE; pixel counter, bit counter, gap counter and shift register cleared.
  - A reset mid-frame requires the driver to be reset as well; no partial-frame recovery.
- DCK generation:
  - A dck register toggles on every clk edge while busy; otherwise it is held or free-running per the optional feature.
  - DAI and DEN change only on the clk edge where DCK goes 1->0. The driver samples on DCK rising, giving one clk of setup and one clk of hold.
- State machine IDLE -> LOAD -> SHIFT -> GAP -> (LOAD | DONE) -> IDLE.
- IDLE:
  - pix_ready=0, busy=0, DEN=0.
  - A frame_start pulse enters LOAD next clk and sets busy=1.
  - frame_start in any other state is ignored.
- LOAD:
  - pix_ready=1 only in LOAD, and only on clk edges where DCK=1, so the load aligns to the next falling DCK.
  - On pix_valid & pix_ready, pix_data is captured into the shift register, then go to SHIFT.
  - While pix_valid=0, remain in LOAD with DEN=0 and DCK still toggling. Extra DEN-low periods only re-commit the previous word in the driver, which is harmless.
- SHIFT:
  - At the first falling DCK: DEN=1, DAI=bit0.
  - Each subsequent falling DCK shifts right; DAI=next bit.
  - After PIX_BITS DCK periods, the falling edge drives DEN=0, DAI=0 and the state moves to GAP.
- GAP:
  - Hold DEN=0 for GAP_DCK DCK periods.
  - Then increment the pixel counter. If the counter equals PIX_PER_FRAME-1 before the increment, go to DONE; otherwise go to LOAD.
- DONE:
  - Hold one clk: frame_done=1, Vsync=1, busy=0, counter wraps to 0.
  - Then go to IDLE.
- Vsync stays 1 until reset; subsequent frames overwrite the driver SRAM in place.
- Timing:
  - Per-pixel cost is (PIX_BITS+GAP_DCK) x 2 clk, i.e. 36 clk at defaults, plus any LOAD stall.
  - Minimum frame length is 512 x 36 = 18432 clk plus start latency.
  - Latency from accept to DEN rising is 1 clk.
- Width rules: pixel counter ceil(log2(PIX_PER_FRAME)) bits, bit counter ceil(log2(PIX_BITS)) bits, gap counter 4 bits.

Optional Feature:
Macro LED_TX_DCK_GATE_EN.
- Defined: DCK is held at 0 in IDLE and does not toggle until frame_start. On the clk after frame_start, dck=1 so LOAD aligns immediately. In DONE, DCK is parked at 0 after the final falling edge.
- Undefined: DCK free-runs at clk/2 from the first clk after reset release, in every state. DEN=0 outside frames.

Test Plan:
- Reset, then frame_start with pix_valid=1 and data 0x0001,0x0002,...,0x0200: a decoding monitor recovers 512 words in order. frame_done pulses exactly once, Vsync=1 after it, and frame length from frame_start is 18432..18434 clk.
- Single word 0xA5C3: DAI sampled at 16 DCK rises while DEN=1 reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first). DEN then stays low for exactly 2 DCK rises.
- Drop pix_valid for 40 clk after word 10: DEN stays 0 and pix_ready stays 1 on DCK-high cycles. Word 11 resumes correctly and the final recovered frame is unchanged.
- Assert rst for 1 clk mid-SHIFT of word 100: all outputs are 0 the next clk and busy=0. A fresh frame_start transmits word 0 correctly.
- frame_start pulsed during SHIFT: ignored, with no change to pixel count or frame_done timing. With LED_TX_DCK_GATE_EN defined, DCK=0 through 20 idle clk; undefined, DCK toggles every clk.

Source files
------------

// File: rtl/led_frame_tx_if.sv
// Pixel-word handshake between the frame source (master) and led_frame_tx (slave).
interface led_frame_tx_if #(
   parameter int unsigned PIX_BITS = 16
);
   logic                pix_valid;
   logic                pix_ready;
   logic [PIX_BITS-1:0] pix_data;

   modport master (output pix_valid, output pix_data, input pix_ready);
   modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/led_frame_tx.sv
// Serialises pixel words LSB-first onto DAI/DEN with a DCK at clk/2 for the LED driver.
// Define LED_TX_DCK_GATE_EN to hold DCK low outside frames; otherwise DCK free-runs.
module led_frame_tx #(
   parameter int unsigned PIX_BITS      = 16,
   parameter int unsigned PIX_PER_FRAME = 512,
   parameter int unsigned GAP_DCK       = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   led_frame_tx_if.slave pix,
   output logic          DCK,
   output logic          DAI,
   output logic          DEN,
   output logic          Vsync,
   output logic          busy,
   output logic          frame_done
);
   localparam int unsigned BitW = (PIX_BITS > 1) ? $clog2(PIX_BITS) : 1;
   localparam int unsigned PixW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;

   typedef enum logic [2:0] {StIdle, StLoad, StShift, StGap, StDone} state_e;

   state_e              state_q;
   logic                dck_q, dai_q, den_q, vsync_q, busy_q, done_q;
   logic [PIX_BITS-1:0] shreg_q;
   logic [BitW-1:0]     bit_cnt_q;
   logic [PixW-1:0]     pix_cnt_q;
   logic [3:0]          gap_cnt_q;

   // A clk edge with dck_q high is a falling DCK edge: the only edge DAI/DEN may move on.
   assign pix.pix_ready = (state_q == StLoad) && dck_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         dck_q     <= 1'b0;
         dai_q     <= 1'b0;
         den_q     <= 1'b0;
         vsync_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         pix_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
`ifdef LED_TX_DCK_GATE_EN
         dck_q  <= busy_q ? ~dck_q : 1'b0;
`else
         dck_q  <= ~dck_q;
`endif
         unique case (state_q)
            StIdle: begin
               if (frame_start) begin
                  state_q <= StLoad;
                  busy_q  <= 1'b1;
`ifdef LED_TX_DCK_GATE_EN
                  dck_q   <= 1'b1;
`endif
               end
            end
            StLoad: begin
               // Capture and drive bit0 on the same falling edge: DEN rises 1 clk after accept.
               if (pix.pix_valid && dck_q) begin
                  dai_q     <= pix.pix_data[0];
                  den_q     <= 1'b1;
                  shreg_q   <= pix.pix_data >> 1;
                  bit_cnt_q <= '0;
                  state_q   <= StShift;
               end
            end
            StShift: begin
               if (dck_q) begin
                  if (bit_cnt_q == BitW'(PIX_BITS - 1)) begin
                     den_q     <= 1'b0;
                     dai_q     <= 1'b0;
                     gap_cnt_q <= '0;
                     state_q   <= StGap;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     dai_q     <= shreg_q[0];
                     shreg_q   <= shreg_q >> 1;
                  end
               end
            end
            StGap: begin
               // Leave on the rising edge so LOAD sees DCK high just before the gap's last fall.
               if (dck_q) begin
                  gap_cnt_q <= gap_cnt_q + 4'd1;
               end else if (gap_cnt_q == 4'(GAP_DCK - 1)) begin
                  if (pix_cnt_q == PixW'(PIX_PER_FRAME - 1)) begin
                     pix_cnt_q <= '0;
                     state_q   <= StDone;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     vsync_q   <= 1'b1;
`ifdef LED_TX_DCK_GATE_EN
                     dck_q     <= 1'b0;
`endif
                  end else begin
                     pix_cnt_q <= pix_cnt_q + 1'b1;
                     state_q   <= StLoad;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign DCK        = dck_q;
   assign DAI        = dai_q;
   assign DEN        = den_q;
   assign Vsync      = vsync_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
endmodule
